// File: rtl/pc_redirect_ctrl.sv
// PC sequencing: merges hazard/fetch stalls into PC_Stall, replays jumps/branches captured
// during a stall once it clears, and traps a hung instruction fetch as a sticky fault.
module pc_redirect_ctrl #(
   parameter int WAIT_TIMEOUT = 255,
   parameter int CNT_W        = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        active,
   input  logic        hazard_stall,
   input  logic        mem_wait,
   input  logic        jump_req,
   input  logic [31:0] jump_target,
   input  logic        branch_req,
   input  logic [31:0] branch_offset,
   output logic        PC_Stall,
   output logic        jump_en,
   output logic        branch_en,
   output logic [31:0] PC_JVal,
   output logic        redirect_busy,
   output logic        redirect_drop,
   output logic        fault
);

   typedef enum logic [2:0] {IDLE, RUN, STALL, STALL_PEND, FAULT} state_t;

   state_t            state;
   logic              pend_jump;
   logic [31:0]       pend_val;
   logic [CNT_W-1:0]  wait_cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              fault_r;
   logic              drop_r;

   logic              stall_in;
   logic              req;
   logic [31:0]       req_val;
   logic              go;
   logic              timeout;

   assign stall_in = hazard_stall | mem_wait;
   assign req      = jump_req | branch_req;
   assign req_val  = jump_req ? jump_target : branch_offset;
   // Outputs are gated during reset so a pending redirect cannot leak out on the reset cycle.
   assign go       = active & ~rst;
   assign cnt_nxt  = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + 1'b1;
   assign timeout  = mem_wait && (cnt_nxt == CNT_W'(WAIT_TIMEOUT));

   assign fault         = fault_r;
   assign redirect_drop = drop_r;

   always_comb begin
      PC_Stall      = 1'b0;
      jump_en       = 1'b0;
      branch_en     = 1'b0;
      PC_JVal       = 32'h0;
      redirect_busy = 1'b0;
      case (state)
         RUN, STALL: if (go) begin
            if (!stall_in) begin
               jump_en   = jump_req;
               branch_en = branch_req & ~jump_req;
               PC_JVal   = req ? req_val : 32'h0;
            end else begin
               PC_Stall      = 1'b1;
               redirect_busy = req;
            end
         end
         STALL_PEND: if (go) begin
            redirect_busy = 1'b1;
            PC_Stall      = stall_in;
            if (!stall_in) begin
               jump_en   = pend_jump;
               branch_en = ~pend_jump;
               PC_JVal   = pend_val;
            end
         end
         FAULT: PC_Stall = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pend_jump <= 1'b0;
         pend_val  <= 32'h0;
         wait_cnt  <= '0;
         fault_r   <= 1'b0;
         drop_r    <= 1'b0;
      end else begin
         drop_r <= 1'b0;
         if (state != FAULT)
            wait_cnt <= mem_wait ? cnt_nxt : '0;
         if (state != FAULT && timeout) begin
            state     <= FAULT;
            fault_r   <= 1'b1;
            pend_jump <= 1'b0;
            pend_val  <= 32'h0;
         end else begin
            case (state)
               IDLE: if (active) state <= RUN;
               RUN, STALL: begin
                  if (!active) state <= IDLE;
                  else if (!stall_in) state <= RUN;
                  else if (req) begin
                     state     <= STALL_PEND;
                     pend_jump <= jump_req;
                     pend_val  <= req_val;
                  end else state <= STALL;
               end
               STALL_PEND: begin
                  if (!active) begin
                     state     <= IDLE;
                     pend_jump <= 1'b0;
                     pend_val  <= 32'h0;
                  end else begin
                     // Pending redirect has priority; a newcomer is discarded and reported.
                     drop_r <= req;
                     if (!stall_in) begin
                        state     <= RUN;
                        pend_jump <= 1'b0;
                        pend_val  <= 32'h0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scenario bench for pc_redirect_ctrl: expected redirects queued at stimulus time,
// popped and compared when the DUT raises jump_en/branch_en.
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst, active, hazard_stall, mem_wait, jump_req, branch_req;
   logic [31:0] jump_target, branch_offset;
   logic        PC_Stall, jump_en, branch_en, redirect_busy, redirect_drop, fault;
   logic [31:0] PC_JVal;

   typedef struct packed {logic j; logic b; logic [31:0] v;} redir_t;
   redir_t exp_q[$];
   redir_t e;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pc_redirect_ctrl #(.WAIT_TIMEOUT(255), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .active(active), .hazard_stall(hazard_stall),
      .mem_wait(mem_wait), .jump_req(jump_req), .jump_target(jump_target),
      .branch_req(branch_req), .branch_offset(branch_offset),
      .PC_Stall(PC_Stall), .jump_en(jump_en), .branch_en(branch_en),
      .PC_JVal(PC_JVal), .redirect_busy(redirect_busy),
      .redirect_drop(redirect_drop), .fault(fault)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic clr_req();
      jump_req = 1'b0; branch_req = 1'b0; jump_target = '0; branch_offset = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; active = 1'b0; hazard_stall = 1'b0; mem_wait = 1'b0; clr_req();
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if ({PC_Stall, jump_en, branch_en, PC_JVal, redirect_busy, redirect_drop, fault} !== 38'h0) begin
         n_bad++; $display("FAIL reset_outputs: got %h want 0",
            {PC_Stall, jump_en, branch_en, PC_JVal, redirect_busy, redirect_drop, fault});
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk); active = 1'b1; jump_req = 1'b1; jump_target = 32'h1234;
      #1;
      n_cmp++;
      if ({jump_en, PC_Stall, PC_JVal} !== 34'h0) begin
         n_bad++; $display("FAIL idle_silent: got en=%b stall=%b val=%h want 0", jump_en, PC_Stall, PC_JVal);
      end
      @(negedge clk); clr_req();
   endtask

   task automatic test_jump();
      jump_req = 1'b1; jump_target = 32'hBFC00100;
      exp_q.push_back('{1'b1, 1'b0, 32'hBFC00100});
      #1;
      if (jump_en | branch_en) begin
         e = '0; if (exp_q.size() != 0) e = exp_q.pop_front();
         n_cmp++;
         if ({jump_en, branch_en, PC_JVal} !== e) begin
            n_bad++; $display("FAIL jump_pass: got j=%b b=%b val=%h want j=%b b=%b val=%h",
               jump_en, branch_en, PC_JVal, e.j, e.b, e.v);
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL jump_pass_missing: got no redirect want %0d queued", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      jump_req = 1'b1; jump_target = 32'h0000_0400; branch_req = 1'b1; branch_offset = 32'h0000_0008;
      exp_q.push_back('{1'b1, 1'b0, 32'h0000_0400});
      #1;
      if (jump_en | branch_en) begin
         e = '0; if (exp_q.size() != 0) e = exp_q.pop_front();
         n_cmp++;
         if ({jump_en, branch_en, PC_JVal} !== e) begin
            n_bad++; $display("FAIL jump_wins: got j=%b b=%b val=%h want j=%b b=%b val=%h",
               jump_en, branch_en, PC_JVal, e.j, e.b, e.v);
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL jump_wins_missing: queued %0d want 0", exp_q.size()); exp_q.delete();
      end
      @(negedge clk); clr_req();
      #1;
      n_cmp++;
      if ({jump_en, branch_en, PC_JVal, redirect_drop} !== 35'h0) begin
         n_bad++; $display("FAIL quiet_run: got j=%b b=%b val=%h drop=%b want 0",
            jump_en, branch_en, PC_JVal, redirect_drop);
      end
   endtask

   task automatic test_stall_branch();
      @(negedge clk); mem_wait = 1'b1; branch_req = 1'b1; branch_offset = 32'h0000_0010;
      exp_q.push_back('{1'b0, 1'b1, 32'h0000_0010});
      for (int c = 1; c <= 3; c++) begin
         if (c > 1) begin @(negedge clk); clr_req(); end
         #1;
         n_cmp++;
         if ({PC_Stall, redirect_busy, jump_en, branch_en} !== 4'b1100) begin
            n_bad++; $display("FAIL stall_cycle%0d: got stall=%b busy=%b j=%b b=%b want 1 1 0 0",
               c, PC_Stall, redirect_busy, jump_en, branch_en);
         end
      end
      @(negedge clk); mem_wait = 1'b0;
      #1;
      if (jump_en | branch_en) begin
         e = '0; if (exp_q.size() != 0) e = exp_q.pop_front();
         n_cmp++;
         if ({jump_en, branch_en, PC_JVal} !== e) begin
            n_bad++; $display("FAIL branch_release: got j=%b b=%b val=%h want j=%b b=%b val=%h",
               jump_en, branch_en, PC_JVal, e.j, e.b, e.v);
         end
      end
      n_cmp++;
      if (exp_q.size() != 0 || PC_Stall !== 1'b0) begin
         n_bad++; $display("FAIL branch_release_missing: queued %0d stall=%b want 0 0", exp_q.size(), PC_Stall);
         exp_q.delete();
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({redirect_busy, branch_en, jump_en} !== 3'b000) begin
         n_bad++; $display("FAIL after_release: got busy=%b b=%b j=%b want 0", redirect_busy, branch_en, jump_en);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk); mem_wait = 1'b1; jump_req = 1'b1; jump_target = 32'h0000_0100;
      exp_q.push_back('{1'b1, 1'b0, 32'h0000_0100});
      @(negedge clk); mem_wait = 1'b0; clr_req(); branch_req = 1'b1; branch_offset = 32'h0000_0044;
      #1;
      if (jump_en | branch_en) begin
         e = '0; if (exp_q.size() != 0) e = exp_q.pop_front();
         n_cmp++;
         if ({jump_en, branch_en, PC_JVal} !== e) begin
            n_bad++; $display("FAIL pending_wins: got j=%b b=%b val=%h want j=%b b=%b val=%h",
               jump_en, branch_en, PC_JVal, e.j, e.b, e.v);
         end
      end
      n_cmp++;
      if (exp_q.size() != 0 || redirect_drop !== 1'b0) begin
         n_bad++; $display("FAIL pending_wins_missing: queued %0d drop=%b want 0 0", exp_q.size(), redirect_drop);
         exp_q.delete();
      end
      @(negedge clk); clr_req();
      #1;
      n_cmp++;
      if ({redirect_drop, jump_en, branch_en} !== 3'b100) begin
         n_bad++; $display("FAIL drop_pulse: got drop=%b j=%b b=%b want 1 0 0", redirect_drop, jump_en, branch_en);
      end
      @(negedge clk); #1;
      n_cmp++;
      if (redirect_drop !== 1'b0) begin
         n_bad++; $display("FAIL drop_width: got %b want 0", redirect_drop);
      end
   endtask

   task automatic test_active_drop();
      @(negedge clk); mem_wait = 1'b1; branch_req = 1'b1; branch_offset = 32'h0000_0020;
      @(negedge clk); clr_req(); active = 1'b0;
      @(negedge clk); mem_wait = 1'b0;
      #1;
      n_cmp++;
      if ({PC_Stall, jump_en, branch_en, PC_JVal, redirect_busy, redirect_drop} !== 37'h0) begin
         n_bad++; $display("FAIL inactive_outputs: got %h want 0",
            {PC_Stall, jump_en, branch_en, PC_JVal, redirect_busy, redirect_drop});
      end
      @(negedge clk); active = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         n_cmp++;
         if ({jump_en, branch_en, redirect_busy} !== 3'b000) begin
            n_bad++; $display("FAIL pend_cleared%0d: got j=%b b=%b busy=%b want 0", c, jump_en, branch_en, redirect_busy);
         end
      end
   endtask

   task automatic test_rst_pending();
      @(negedge clk); mem_wait = 1'b1; jump_req = 1'b1; jump_target = 32'h0000_0200;
      @(negedge clk); clr_req(); rst = 1'b1; mem_wait = 1'b0;
      #1;
      n_cmp++;
      if ({jump_en, branch_en} !== 2'b00) begin
         n_bad++; $display("FAIL rst_cycle_redirect: got j=%b b=%b want 0", jump_en, branch_en);
      end
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         n_cmp++;
         if ({jump_en, branch_en, redirect_busy} !== 3'b000) begin
            n_bad++; $display("FAIL rst_discard%0d: got j=%b b=%b busy=%b want 0", c, jump_en, branch_en, redirect_busy);
         end
      end
   endtask

   task automatic test_hazard();
      @(negedge clk); hazard_stall = 1'b1;
      repeat (300) @(negedge clk);
      #1;
      n_cmp++;
      if ({fault, PC_Stall} !== 2'b01) begin
         n_bad++; $display("FAIL hazard_no_timeout: got fault=%b stall=%b want 0 1", fault, PC_Stall);
      end
      @(negedge clk); hazard_stall = 1'b0;
      #1;
      n_cmp++;
      if (PC_Stall !== 1'b0) begin
         n_bad++; $display("FAIL hazard_release: got stall=%b want 0", PC_Stall);
      end
   endtask

   task automatic test_fault();
      @(negedge clk); mem_wait = 1'b1;
      repeat (254) @(negedge clk);
      #1;
      n_cmp++;
      if ({fault, PC_Stall} !== 2'b01) begin
         n_bad++; $display("FAIL fault_early: got fault=%b stall=%b want 0 1", fault, PC_Stall);
      end
      @(negedge clk); #1;
      n_cmp++;
      if ({fault, PC_Stall} !== 2'b11) begin
         n_bad++; $display("FAIL fault_set: got fault=%b stall=%b want 1 1", fault, PC_Stall);
      end
      mem_wait = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); active = c[0]; jump_req = 1'b1; jump_target = 32'h0000_0300;
         #1;
         n_cmp++;
         if ({fault, PC_Stall, jump_en, branch_en, PC_JVal} !== {2'b11, 34'h0}) begin
            n_bad++; $display("FAIL fault_sticky%0d: got fault=%b stall=%b j=%b b=%b val=%h want 1 1 0 0 0",
               c, fault, PC_Stall, jump_en, branch_en, PC_JVal);
         end
      end
      @(negedge clk); clr_req(); active = 1'b1; rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      #1;
      n_cmp++;
      if ({fault, PC_Stall} !== 2'b00) begin
         n_bad++; $display("FAIL fault_rst: got fault=%b stall=%b want 0 0", fault, PC_Stall);
      end
   endtask

   initial begin
      test_reset();
      test_jump();
      test_stall_branch();
      test_back_to_back();
      test_active_drop();
      test_rst_pending();
      test_hazard();
      test_fault();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
